// File: rtl/pc_seq_pkg.sv
// Shared definitions for the pc_sequencer fetch/execute controller:
// state encoding, opcode map and opcode class helpers.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_ADDI  = 4'd7;
    localparam logic [3:0] OP_ANDI  = 4'd8;
    localparam logic [3:0] OP_ORI   = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd10;
    localparam logic [3:0] OP_STORE = 4'd11;
    localparam logic [3:0] OP_JMP   = 4'd12;
    localparam logic [3:0] OP_BEQ   = 4'd13;
    localparam logic [3:0] OP_BNE   = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // ALU / immediate instructions: the ones that finish through WB
    function automatic logic is_rtype(input logic [3:0] op);
        return (op <= OP_ORI) && (op != OP_MUL);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: PC+1 or PC+sign-extended offset, truncated to PC_W,
// plus the check that the result still lies inside the program.
module pc_next_calc #(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [8:0]      address,
    input  logic            take_jump,
    output logic [PC_W-1:0] pc_next,
    output logic            out_of_range
);

    logic [PC_W-1:0] increment;

    // The cast sign-extends or truncates the 9-bit offset to PC_W bits
    assign increment    = take_jump ? PC_W'($signed(address)) : PC_W'(1);
    assign pc_next      = pc + increment;
    assign out_of_range = (32'(pc_next) >= 32'(PROG_LEN));

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the program counter.
// Optional SINGLE_STEP_EN adds a step input that gates FETCH on its rising edge.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int PROG_LEN    = 16,
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      opcode,
    input  logic [8:0]      address,
    input  logic            zero,
    input  logic            mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] PC,
    output logic            ir_load,
    output logic            reg_we,
    output logic            hilo_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            halted,
    output logic            fault
);

    state_t          state;
    logic [3:0]      mul_cnt;
    logic [7:0]      mem_cnt;
    logic            mem_is_load;
    logic            advance;
    logic            branch_taken;
    logic            take_jump;
    logic [PC_W-1:0] pc_new;
    logic            pc_bad;

`ifdef SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign advance = step & ~step_q;
`else
    assign advance = 1'b1;
`endif

    assign branch_taken = (opcode == OP_JMP) ||
                          ((opcode == OP_BEQ) && zero) ||
                          ((opcode == OP_BNE) && !zero);
    // Only EXEC ever commits a jump target; every other PC update is PC+1
    assign take_jump = (state == S_EXEC) && branch_taken;

    pc_next_calc #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc_next_calc (
        .pc           (PC),
        .address      (address),
        .take_jump    (take_jump),
        .pc_next      (pc_new),
        .out_of_range (pc_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            PC          <= '0;
            mul_cnt     <= '0;
            mem_cnt     <= '0;
            mem_is_load <= 1'b0;
            ir_load     <= 1'b0;
            reg_we      <= 1'b0;
            hilo_we     <= 1'b0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // Pulse-type outputs are asserted only by the transition that needs them
            ir_load <= 1'b0;
            reg_we  <= 1'b0;
            hilo_we <= 1'b0;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;

            case (state)
                S_FETCH: begin
                    if (advance) begin
                        state   <= S_DECODE;
                        ir_load <= 1'b1;
                    end
                end

                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (is_jump(opcode)) begin
                        if (pc_bad) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            PC    <= pc_new;
                            state <= S_FETCH;
                        end
                    end else if (opcode == OP_MUL) begin
                        mul_cnt <= 4'(MUL_CYCLES - 1);
                        hilo_we <= (MUL_CYCLES == 1);
                        state   <= S_MUL_WAIT;
                    end else if (is_mem(opcode)) begin
                        mem_cnt     <= '0;
                        mem_is_load <= (opcode == OP_LOAD);
                        mem_re      <= (opcode == OP_LOAD);
                        mem_we      <= (opcode == OP_STORE);
                        state       <= S_MEM_WAIT;
                    end else begin
                        reg_we <= 1'b1;
                        state  <= S_WB;
                    end
                end

                S_MUL_WAIT: begin
                    if (mul_cnt == 4'd0) begin
                        if (pc_bad) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            PC    <= pc_new;
                            state <= S_FETCH;
                        end
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                        hilo_we <= (mul_cnt == 4'd1);
                    end
                end

                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        if (mem_is_load) begin
                            reg_we <= 1'b1;
                            state  <= S_WB;
                        end else if (pc_bad) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            PC    <= pc_new;
                            state <= S_FETCH;
                        end
                    end else if (mem_cnt == 8'(MEM_TIMEOUT - 1)) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        mem_cnt <= mem_cnt + 8'd1;
                        mem_re  <= mem_is_load;
                        mem_we  <= !mem_is_load;
                    end
                end

                S_WB: begin
                    if (pc_bad) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        PC    <= pc_new;
                        state <= S_FETCH;
                    end
                end

                S_HALT: begin
                    halted <= 1'b1;
                end

                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model pushes the expected
// outcome of each instruction to a queue, popped when the instruction completes.
module tb_pc_sequencer;

    localparam int PC_W        = 8;
    localparam int PROG_LEN    = 16;
    localparam int MUL_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      opcode = '0;
    logic [8:0]      address = '0;
    logic            zero = 1'b0;
    logic            mem_ready = 1'b0;
    logic [PC_W-1:0] PC;
    logic            ir_load, reg_we, hilo_we, mem_re, mem_we, halted, fault;

    int total = 0;
    int bad   = 0;
    int model_pc = 0;

    typedef struct {
        int pc;
        int cycles;
        int ir_at;
        int reg_cnt;
        int reg_at;
        int hilo_cnt;
        int hilo_at;
        int re_cnt;
        int we_cnt;
        int flt;
        int hlt;
    } rec_t;

    rec_t exp_q[$];

    pc_sequencer #(
        .PC_W        (PC_W),
        .PROG_LEN    (PROG_LEN),
        .MUL_CYCLES  (MUL_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .address   (address),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PC        (PC),
        .ir_load   (ir_load),
        .reg_we    (reg_we),
        .hilo_we   (hilo_we),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Expected outcome of one instruction starting at model_pc.
    // ready_at: MEM_WAIT cycle in which mem_ready is driven (0 = never).
    function automatic rec_t model(input logic [3:0] op, input logic [8:0] addr,
                                   input logic z, input int ready_at);
        rec_t e;
        int   off;
        int   nxt;
        bit   upd;
        bit   take;
        e = '{default: 0};
        e.ir_at = 2;
        e.pc    = model_pc;
        upd     = 1'b1;
        take    = 1'b0;
        off     = addr[8] ? int'(addr) - 512 : int'(addr);
        case (op)
            4'd15: begin
                e.cycles = 2;
                e.hlt    = 1;
                upd      = 1'b0;
            end
            4'd3: begin
                e.cycles   = 3 + MUL_CYCLES;
                e.hilo_cnt = 1;
                e.hilo_at  = 3 + MUL_CYCLES;
            end
            4'd10, 4'd11: begin
                if (ready_at == 0) begin
                    e.cycles = 3 + MEM_TIMEOUT;
                    e.flt    = 1;
                    e.hlt    = 1;
                    upd      = 1'b0;
                    if (op == 4'd10) e.re_cnt = MEM_TIMEOUT;
                    else             e.we_cnt = MEM_TIMEOUT;
                end else if (op == 4'd10) begin
                    e.re_cnt  = ready_at;
                    e.cycles  = 4 + ready_at;
                    e.reg_cnt = 1;
                    e.reg_at  = 4 + ready_at;
                end else begin
                    e.we_cnt = ready_at;
                    e.cycles = 3 + ready_at;
                end
            end
            4'd12, 4'd13, 4'd14: begin
                e.cycles = 3;
                take = (op == 4'd12) || (op == 4'd13 && z) || (op == 4'd14 && !z);
            end
            default: begin
                e.cycles  = 4;
                e.reg_cnt = 1;
                e.reg_at  = 4;
            end
        endcase
        if (upd) begin
            nxt = take ? ((model_pc + off) & 255) : ((model_pc + 1) & 255);
            if (nxt >= PROG_LEN) begin
                e.flt = 1;
                e.hlt = 1;
            end else begin
                e.pc = nxt;
            end
        end
        return e;
    endfunction

    // Called at a negedge while the DUT sits in FETCH.
    task automatic run_instr(input string name, input logic [3:0] op, input logic [8:0] addr,
                             input logic z, input int ready_at);
        rec_t a;
        rec_t e;
        int   start_pc;
        int   memc;
        bit   done;
        a        = '{default: 0};
        start_pc = int'(PC);
        memc     = 0;
        done     = 1'b0;
        exp_q.push_back(model(op, addr, z, ready_at));
        opcode    = op;
        address   = addr;
        zero      = z;
        mem_ready = 1'b0;
        for (int c = 1; c <= 100 && !done; c++) begin
            if (ir_load && a.ir_at == 0) a.ir_at = c;
            if (reg_we) begin
                a.reg_cnt++;
                if (a.reg_at == 0) a.reg_at = c;
            end
            if (hilo_we) begin
                a.hilo_cnt++;
                if (a.hilo_at == 0) a.hilo_at = c;
            end
            if (mem_re) a.re_cnt++;
            if (mem_we) a.we_cnt++;
            if (mem_re || mem_we) begin
                memc++;
                mem_ready = (ready_at != 0) && (memc >= ready_at);
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            if (int'(PC) != start_pc || halted) begin
                done     = 1'b1;
                a.cycles = c;
            end
        end
        mem_ready = 1'b0;
        a.pc  = int'(PC);
        a.flt = int'(fault);
        a.hlt = int'(halted);
        chk({name, ".done"}, int'(done), 1);
        e = exp_q.pop_front();
        chk({name, ".pc"}, a.pc, e.pc);
        chk({name, ".cycles"}, a.cycles, e.cycles);
        chk({name, ".ir_at"}, a.ir_at, e.ir_at);
        chk({name, ".reg_cnt"}, a.reg_cnt, e.reg_cnt);
        chk({name, ".reg_at"}, a.reg_at, e.reg_at);
        chk({name, ".hilo_cnt"}, a.hilo_cnt, e.hilo_cnt);
        chk({name, ".hilo_at"}, a.hilo_at, e.hilo_at);
        chk({name, ".re_cnt"}, a.re_cnt, e.re_cnt);
        chk({name, ".we_cnt"}, a.we_cnt, e.we_cnt);
        chk({name, ".fault"}, a.flt, e.flt);
        chk({name, ".halted"}, a.hlt, e.hlt);
        $display("instr %s op=%0d addr=%03h zero=%0d -> pc=%0d cycles=%0d fault=%0d halted=%0d",
                 name, op, addr, z, a.pc, a.cycles, a.flt, a.hlt);
        model_pc = e.pc;
    endtask

    task automatic do_reset(input string name);
        rst       = 1'b1;
        opcode    = '0;
        address   = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({name, ".pc"}, int'(PC), 0);
        chk({name, ".outs"}, int'({ir_load, reg_we, hilo_we, mem_re, mem_we, halted, fault}), 0);
        $display("reset %s pc=%0d", name, PC);
        rst      = 1'b0;
        model_pc = 0;
    endtask

    initial begin
        do_reset("rst0");
        run_instr("add",      4'd0,  9'h000, 1'b0, 0);
        run_instr("jmp_p4",   4'd12, 9'h004, 1'b0, 0);
        run_instr("jmp_m2",   4'd12, 9'h1FE, 1'b0, 0);
        run_instr("sub",      4'd1,  9'h000, 1'b0, 0);
        run_instr("beq_nt",   4'd13, 9'h003, 1'b0, 0);
        run_instr("jmp_m1",   4'd12, 9'h1FF, 1'b0, 0);
        run_instr("beq_t",    4'd13, 9'h003, 1'b1, 0);
        run_instr("jmp_m3",   4'd12, 9'h1FD, 1'b0, 0);
        run_instr("bne_t",    4'd14, 9'h003, 1'b0, 0);
        run_instr("bne_nt",   4'd14, 9'h003, 1'b1, 0);
        run_instr("mul",      4'd3,  9'h000, 1'b0, 0);
        run_instr("load2",    4'd10, 9'h000, 1'b0, 2);
        run_instr("store1",   4'd11, 9'h000, 1'b0, 1);
        run_instr("load1",    4'd10, 9'h000, 1'b0, 1);
        run_instr("jmp_p2",   4'd12, 9'h002, 1'b0, 0);
        run_instr("jmp_oob",  4'd12, 9'h005, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            opcode = 4'd0;
            @(negedge clk);
            chk("halt_hold.pc", int'(PC), 14);
            chk("halt_hold.en", int'({ir_load, reg_we, hilo_we, mem_re, mem_we, halted}), 1);
        end

        do_reset("rst1");
        run_instr("jmp_p15",  4'd12, 9'h00F, 1'b0, 0);
        run_instr("wb_oob",   4'd0,  9'h000, 1'b0, 0);

        do_reset("rst2");
        run_instr("jmp_p6",   4'd12, 9'h006, 1'b0, 0);
        opcode = 4'd3;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.pc", int'(PC), 0);
        chk("mid_rst.outs", int'({ir_load, reg_we, hilo_we, mem_re, mem_we, halted, fault}), 0);
        $display("reset mid_rst pc=%0d", PC);
        @(negedge clk);
        rst      = 1'b0;
        model_pc = 0;
        run_instr("store_to", 4'd11, 9'h000, 1'b0, 0);

        do_reset("rst3");
        run_instr("halt",     4'd15, 9'h000, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
